// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, encoder states, error codes and the field bundle
// consumed by the instruction encoder and the control unit.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd1;
  localparam logic [5:0] OP_ORI   = 6'd2;
  localparam logic [5:0] OP_ANDI  = 6'd3;
  localparam logic [5:0] OP_LW    = 6'd4;
  localparam logic [5:0] OP_SW    = 6'd5;
  localparam logic [5:0] OP_BEQ   = 6'd6;
  localparam logic [5:0] OP_BGT   = 6'd7;
  localparam logic [5:0] OP_J     = 6'd8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READY = 2'd1,
    ST_WRITE = 2'd2,
    ST_FULL  = 2'd3
  } enc_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } instr_fields_t;

endpackage

// File: rtl/instr_format.sv
// Combinational instruction word formatter: packs fields into a 32-bit word and flags
// illegal opcodes and branch offsets that do not fit in 16 signed bits.
module instr_format
  import cpu_pkg::*;
(
  input  instr_fields_t      fields,
  input  logic signed [31:0] offset,
  output logic        [31:0] word,
  output logic               illegal,
  output logic               range_err
);

  always_comb begin
    word       = '0;
    illegal    = 1'b0;
    range_err  = 1'b0;
    word[31:26] = fields.op;
    case (fields.op)
      OP_RTYPE:
        word[25:0] = {fields.rs, fields.rt, fields.rd, fields.shamt, fields.funct};
      OP_ADDI, OP_ORI, OP_ANDI, OP_LW, OP_SW:
        word[25:0] = {fields.rs, fields.rt, fields.imm};
      OP_BEQ, OP_BGT: begin
        word[25:0] = {fields.rs, fields.rt, offset[15:0]};
        range_err  = (offset > 32'sd32767) || (offset < -32'sd32768);
      end
      OP_J:
        word[25:0] = fields.target;
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts instruction fields, formats them and writes the words
// sequentially into instruction memory with a held-until-ack write handshake.
module instr_encoder
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam int unsigned CW = ADDR_W + 1;
  localparam int unsigned OW = ADDR_W + 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  enc_state_t         state;
  instr_fields_t      fields;
  logic [OW-1:0]      diff;
  logic signed [31:0] offset;
  logic [31:0]        word;
  logic               illegal;
  logic               range_err;

  assign fields = '{op: in_op, rs: in_rs, rt: in_rt, rd: in_rd, shamt: in_shamt,
                    funct: in_funct, imm: in_imm, target: in_target};

  // Branch offset is relative to the word after the one being written (mem_addr is the pointer).
  assign diff   = OW'(in_target[ADDR_W-1:0]) - OW'(mem_addr) - OW'(1);
  assign offset = {{(32-OW){diff[OW-1]}}, diff};

  instr_format u_format (
    .fields    (fields),
    .offset    (offset),
    .word      (word),
    .illegal   (illegal),
    .range_err (range_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      count     <= '0;
      full      <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      err <= 1'b0;
      if (start && state != ST_WRITE) begin
        state    <= ST_READY;
        in_ready <= 1'b1;
        mem_addr <= start_addr;
        count    <= '0;
        full     <= 1'b0;
        err_code <= ERR_NONE;
      end else begin
        case (state)
          ST_READY: begin
            if (in_valid) begin
              if (illegal) begin
                err      <= 1'b1;
                err_code <= ERR_ILLEGAL;
              end else if (range_err) begin
                err      <= 1'b1;
                err_code <= ERR_RANGE;
              end else begin
                state     <= ST_WRITE;
                in_ready  <= 1'b0;
                mem_we    <= 1'b1;
                mem_wdata <= word;
              end
            end
          end
          ST_WRITE: begin
            if (mem_ack) begin
              mem_we <= 1'b0;
              count  <= count + CW'(1);
              // The last word pins the pointer instead of wrapping.
              if (mem_addr == LAST_ADDR) begin
                state <= ST_FULL;
                full  <= 1'b1;
              end else begin
                state    <= ST_READY;
                in_ready <= 1'b1;
                mem_addr <= mem_addr + ADDR_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized traffic
// compared against an arithmetic reference model of the encoding rules.
module tb_instr_encoder;

  localparam int unsigned AW = 16;
  localparam int unsigned CW = AW + 1;
  localparam int DP = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    in_op;
  logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
  logic [5:0]    in_funct;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ack;
  logic [AW:0]   count;
  logic          full;
  logic          err;
  logic [1:0]    err_code;

  instr_encoder #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
    .in_funct(in_funct), .in_imm(in_imm), .in_target(in_target),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .count(count), .full(full), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_ptr  = 0;
  int m_cnt  = 0;
  bit m_full = 1'b0;

  // Reference encoding: ec 0 = word written, 1 = illegal opcode, 2 = branch out of range.
  function automatic void ref_encode(input int op, input int rs, input int rt, input int rd,
                                     input int sh, input int fn, input int imm, input int tgt,
                                     input int ptr, output logic [31:0] w, output int ec);
    int off;
    w  = 32'h0;
    ec = 0;
    if (op > 8) begin
      ec = 1;
    end else if (op == 0) begin
      w = (rs << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn;
    end else if (op <= 5) begin
      w = (op << 26) | (rs << 21) | (rt << 16) | imm;
    end else if (op <= 7) begin
      off = (tgt % (1 << AW)) - (ptr + 1);
      if (off > 32767 || off < -32768) ec = 2;
      else w = (op << 26) | (rs << 21) | (rt << 16) | (off & 32'hFFFF);
    end else begin
      w = (op << 26) | tgt;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int addr);
    start      = 1'b1;
    start_addr = AW'(addr);
    step();
    start  = 1'b0;
    m_ptr  = addr;
    m_cnt  = 0;
    m_full = 1'b0;
  endtask

  task automatic issue(input string name, input int op, input int rs, input int rt,
                       input int rd, input int sh, input int fn, input int imm, input int tgt,
                       output bit wrote, output logic [31:0] w);
    int ec;
    ref_encode(op, rs, rt, rd, sh, fn, imm, tgt, m_ptr, w, ec);
    in_op = 6'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_shamt = 5'(sh); in_funct = 6'(fn); in_imm = 16'(imm); in_target = 26'(tgt);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++;
    if (ec == 0) begin
      wrote = 1'b1;
      if (mem_we !== 1'b1 || mem_addr !== AW'(m_ptr) || mem_wdata !== w ||
          in_ready !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL %s write: we=%b addr=%0d data=%h rdy=%b err=%b, expected we=1 addr=%0d data=%h rdy=0 err=0",
                 name, mem_we, mem_addr, mem_wdata, in_ready, err, m_ptr, w);
      end
    end else begin
      wrote = 1'b0;
      if (err !== 1'b1 || err_code !== 2'(ec) || mem_we !== 1'b0 || in_ready !== 1'b1 ||
          count !== CW'(m_cnt) || mem_addr !== AW'(m_ptr)) begin
        errors++;
        $display("FAIL %s error: err=%b code=%b we=%b rdy=%b cnt=%0d addr=%0d, expected err=1 code=%0d we=0 rdy=1 cnt=%0d addr=%0d",
                 name, err, err_code, mem_we, in_ready, count, mem_addr, ec, m_cnt, m_ptr);
      end
    end
  endtask

  task automatic finish_write(input string name, input int hold, input logic [31:0] w);
    for (int i = 0; i < hold; i++) begin
      step();
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== AW'(m_ptr) || mem_wdata !== w || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold%0d: we=%b addr=%0d data=%h rdy=%b, expected we=1 addr=%0d data=%h rdy=0",
                 name, i, mem_we, mem_addr, mem_wdata, in_ready, m_ptr, w);
      end
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    m_cnt++;
    if (m_ptr == DP - 1) m_full = 1'b1;
    else m_ptr++;
    checks++;
    if (mem_we !== 1'b0 || count !== CW'(m_cnt) || full !== m_full ||
        in_ready !== (m_full ? 1'b0 : 1'b1) || mem_addr !== AW'(m_ptr)) begin
      errors++;
      $display("FAIL %s ack: we=%b cnt=%0d full=%b rdy=%b addr=%0d, expected we=0 cnt=%0d full=%b rdy=%b addr=%0d",
               name, mem_we, count, full, in_ready, mem_addr, m_cnt, m_full, !m_full, m_ptr);
    end
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
        count !== '0 || full !== 1'b0 || err !== 1'b0 || err_code !== 2'b00) begin
      errors++;
      $display("FAIL reset: rdy=%b we=%b addr=%0d data=%h cnt=%0d full=%b err=%b code=%b, expected all zero",
               in_ready, mem_we, mem_addr, mem_wdata, count, full, err, err_code);
    end
    rst = 1'b0;
    // fields presented while idle must be dropped silently
    in_valid = 1'b1; in_op = 6'd1;
    step();
    in_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid: we=%b err=%b rdy=%b, expected 0 0 0", mem_we, err, in_ready);
    end
  endtask

  task automatic test_directed();
    bit wr;
    logic [31:0] w;
    do_start(0);
    issue("addi", 1, 1, 2, 0, 0, 0, 5, 0, wr, w);
    checks++;
    if (w !== 32'h04220005) begin
      errors++;
      $display("FAIL addi_model: got %h expected 04220005", w);
    end
    finish_write("addi", 0, w);
    issue("rtype", 0, 1, 2, 3, 0, 32, 0, 0, wr, w);
    checks++;
    if (mem_wdata !== 32'h00221820) begin
      errors++;
      $display("FAIL rtype_word: got %h expected 00221820", mem_wdata);
    end
    finish_write("rtype", 1, w);
    do_start(4);
    issue("beq", 6, 3, 4, 0, 0, 0, 0, 2, wr, w);
    checks++;
    if (mem_wdata !== 32'h1864FFFD) begin
      errors++;
      $display("FAIL beq_word: got %h expected 1864fffd", mem_wdata);
    end
    finish_write("beq", 0, w);
    issue("j", 8, 0, 0, 0, 0, 0, 0, 32'h10, wr, w);
    checks++;
    if (mem_wdata !== 32'h20000010) begin
      errors++;
      $display("FAIL j_word: got %h expected 20000010", mem_wdata);
    end
    finish_write("j", 0, w);
  endtask

  task automatic test_illegal();
    bit wr;
    logic [31:0] w;
    issue("op9", 9, 1, 2, 3, 4, 5, 6, 7, wr, w);
    step();
    checks++;
    if (err !== 1'b0 || err_code !== 2'b01 || in_ready !== 1'b1 || count !== CW'(m_cnt)) begin
      errors++;
      $display("FAIL op9_after: err=%b code=%b rdy=%b cnt=%0d, expected err=0 code=01 rdy=1 cnt=%0d",
               err, err_code, in_ready, count, m_cnt);
    end
    do_start(20);
    checks++;
    if (err_code !== 2'b00 || count !== '0 || mem_addr !== AW'(20)) begin
      errors++;
      $display("FAIL restart_clear: code=%b cnt=%0d addr=%0d, expected code=00 cnt=0 addr=20",
               err_code, count, mem_addr);
    end
  endtask

  task automatic test_range();
    bit wr;
    logic [31:0] w;
    do_start(0);
    issue("beq_far", 6, 1, 1, 0, 0, 0, 0, 40000, wr, w);
    issue("bgt_max", 7, 2, 3, 0, 0, 0, 0, 32768, wr, w);
    if (wr) finish_write("bgt_max", 0, w);
    issue("bgt_edge_ok", 7, 5, 6, 0, 0, 0, 0, 32769, wr, w);
    if (wr) finish_write("bgt_edge_ok", 0, w);
    issue("bgt_edge_bad", 7, 5, 6, 0, 0, 0, 0, 32771, wr, w);
    issue("beq_hibits", 6, 7, 8, 0, 0, 0, 0, 26'h3FF0001, wr, w);
    if (wr) finish_write("beq_hibits", 0, w);
  endtask

  task automatic test_stall();
    bit wr;
    logic [31:0] w;
    do_start(50);
    issue("stall", 4, 9, 10, 0, 0, 0, 16'hBEEF, 0, wr, w);
    // start while a write is pending must be ignored
    start = 1'b1; start_addr = AW'(123);
    step();
    start = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== AW'(50) || in_ready !== 1'b0 || mem_wdata !== w) begin
      errors++;
      $display("FAIL start_in_write: we=%b addr=%0d rdy=%b data=%h, expected we=1 addr=50 rdy=0 data=%h",
               mem_we, mem_addr, in_ready, mem_wdata, w);
    end
    finish_write("stall", 5, w);
  endtask

  task automatic test_full();
    bit wr;
    logic [31:0] w;
    do_start(DP - 1);
    issue("last", 8, 0, 0, 0, 0, 0, 0, 26'h2AAAAAA, wr, w);
    finish_write("last", 2, w);
    in_valid = 1'b1; in_op = 6'd1;
    step();
    in_valid = 1'b0;
    checks++;
    if (full !== 1'b1 || in_ready !== 1'b0 || mem_we !== 1'b0 || err !== 1'b0 ||
        mem_addr !== AW'(DP - 1)) begin
      errors++;
      $display("FAIL full_valid: full=%b rdy=%b we=%b err=%b addr=%0d, expected 1 0 0 0 %0d",
               full, in_ready, mem_we, err, mem_addr, DP - 1);
    end
    do_start(3);
    checks++;
    if (full !== 1'b0 || in_ready !== 1'b1 || count !== '0 || mem_addr !== AW'(3)) begin
      errors++;
      $display("FAIL full_restart: full=%b rdy=%b cnt=%0d addr=%0d, expected 0 1 0 3",
               full, in_ready, count, mem_addr);
    end
  endtask

  task automatic test_random();
    bit wr;
    logic [31:0] w;
    int op, tgt;
    for (int n = 0; n < 300; n++) begin
      if (m_full || $urandom_range(15, 0) == 0) begin
        if ($urandom_range(1, 0) == 1) do_start(int'($urandom_range(DP - 1, DP - 3)));
        else do_start(int'($urandom_range(DP - 1, 0)));
      end
      op = int'($urandom_range(10, 0));
      if ($urandom_range(1, 0) == 1) tgt = int'($urandom_range(32'h3FFFFFF, 0));
      else tgt = m_ptr + int'($urandom_range(33000, 0)) - 200;
      if (tgt < 0) tgt = 0;
      issue("rand", op, int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
            int'($urandom_range(31, 0)), int'($urandom_range(31, 0)),
            int'($urandom_range(63, 0)), int'($urandom_range(16'hFFFF, 0)), tgt, wr, w);
      if (wr) finish_write("rand", int'($urandom_range(3, 0)), w);
    end
  endtask

  task automatic test_rst_mid_write();
    bit wr;
    logic [31:0] w;
    do_start(10);
    issue("pre_rst", 2, 4, 5, 0, 0, 0, 16'h1234, 0, wr, w);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
        count !== '0 || full !== 1'b0 || err !== 1'b0 || err_code !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid_write: rdy=%b we=%b addr=%0d data=%h cnt=%0d full=%b err=%b code=%b, expected all zero",
               in_ready, mem_we, mem_addr, mem_wdata, count, full, err, err_code);
    end
    mem_ack = 1'b1;
    step();
    rst = 1'b0;
    step();
    mem_ack = 1'b0;
    checks++;
    if (mem_we !== 1'b0 || count !== '0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_idle: we=%b cnt=%0d rdy=%b, expected 0 0 0", mem_we, count, in_ready);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; in_valid = 1'b0; mem_ack = 1'b0;
    in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_funct = '0; in_imm = '0; in_target = '0;
    test_reset();
    test_directed();
    test_illegal();
    test_range();
    test_stall();
    test_full();
    test_random();
    test_rst_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: ADDR_W, default 8, instruction-memory word-address width.
REQ-002 Parameter: DEPTH, default 2**ADDR_W, number of writable words.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  pulse: arm encoder, load write pointer from start_addr, clear count.
REQ-006 start_addr  in  ADDR_W  first word address to write.
REQ-007 in_valid  in  1  instruction fields valid.
REQ-008 in_ready  out  1  encoder can accept fields.
REQ-009 in_op  in  6  opcode: 0 R-type, 1 addi, 2 ori, 3 andi, 4 lw, 5 sw, 6 beq, 7 bgt, 8 j.
REQ-010 in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
REQ-011 in_funct  in  6  R-type function field.
REQ-012 in_imm  in  16  immediate for opcodes 1-5.
REQ-013 in_target  in  26  j: absolute target; beq/bgt: absolute word address of branch target.
REQ-014 mem_we  out  1  instruction-memory write request.
REQ-015 mem_addr  out  ADDR_W  write address.
REQ-016 mem_wdata  out  32  encoded instruction word.
REQ-017 mem_ack  in  1  memory accepted current write.
REQ-018 count  out  ADDR_W+1  words written since last start.
REQ-019 full  out  1  write pointer exhausted.
REQ-020 err  out  1  one-cycle error pulse; err_code  out  2  01 illegal opcode, 10 branch offset out of range.

Function
REQ-021 States SHALL be IDLE, READY, WRITE, FULL; in_ready SHALL be 1 only in READY.
REQ-022 start in IDLE, READY or FULL SHALL go to READY next cycle; start in WRITE SHALL be ignored.
REQ-023 Handshake: fields accepted on cycle with in_valid & in_ready; encoded word registered, mem_we=1 from next cycle (latency 1), state WRITE.
REQ-024 In WRITE, mem_we, mem_addr, mem_wdata SHALL hold stable until mem_ack=1; on ack: mem_we=0 next cycle, pointer+1, count+1.
REQ-025 After ack, if pointer was DEPTH-1 SHALL go FULL (full=1, no wrap), else READY.
REQ-026 Encoding: [31:26]=in_op; R-type [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct.
REQ-027 Opcodes 1-5: [25:21] rs, [20:16] rt, [15:0] in_imm unmodified.
REQ-028 beq/bgt: [15:0] = in_target[ADDR_W-1:0] - (mem_addr+1), signed, computed at ADDR_W+2 bits.
REQ-029 Branch offset outside -32768..32767 SHALL not write: err=1, err_code=10 one cycle, remain READY, pointer unchanged.
REQ-030 j: [25:0]=in_target.
REQ-031 in_op > 8 SHALL not write: err=1, err_code=01 one cycle, remain READY.
REQ-032 err_code SHALL hold last error value until next start or reset.
REQ-033 in_valid in IDLE, WRITE or FULL SHALL be ignored with no error.

Reset
REQ-034 rst SHALL force IDLE immediately: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, err=0, err_code=00.
REQ-035 rst during WRITE SHALL drop mem_we asynchronously; pending word lost.

Structure
REQ-036 Opcode constants (OP_RTYPE..OP_J), state encodings and err_code values SHALL live in shared package cpu_pkg, also consumed by controlUnit.
REQ-037 Word formatting SHALL be one combinational sub-module instr_format (op, fields, offset -> 32-bit word, illegal flag); FSM, pointer and counters in instr_encoder.

Verification
REQ-038 start, start_addr=0; addi rs=1 rt=2 imm=5 -> mem_addr=0, mem_wdata=0x04220005, count=1 after ack.
REQ-039 R-type rs=1 rt=2 rd=3 funct=0x20 -> mem_wdata=0x00221820.
REQ-040 Pointer at 4; beq rs=3 rt=4 target=2 -> mem_wdata=0x1864FFFD; j target=0x10 -> 0x20000010.
REQ-041 in_op=9 -> err=1 one cycle, err_code=01, no mem_we, count unchanged.
REQ-042 mem_ack held low 5 cycles -> mem_we, addr, data stable, in_ready=0 throughout.
REQ-043 start_addr=DEPTH-1, one write -> full=1, in_ready=0; rst mid-WRITE -> all outputs reset values same cycle.
